tcdm_remap_demux: RTL and testbench



---
 rtl/pkg_soc_interconnect.sv | 14 +
 rtl/tcdm_remap_demux_tracker.sv | 39 +++
 rtl/tcdm_remap_demux.sv | 107 ++++++++++
 tb/tb_tcdm_remap_demux.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_soc_interconnect.sv
// pkg_soc_interconnect: shared interconnect types and target-index helpers
package pkg_soc_interconnect;
   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_map_rule_t;
   function automatic int unsigned err_idx(input int unsigned nr_targets);
      return nr_targets;
   endfunction
   function automatic int unsigned tgt_idx_w(input int unsigned nr_targets);
      return $clog2(nr_targets + 1);
   endfunction
endpackage

// File: rtl/tcdm_remap_demux_tracker.sv
// tcdm_outstanding_tracker: outstanding count, last target and in-order issue gate
module tcdm_outstanding_tracker
   import pkg_soc_interconnect::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned IDX_W           = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [IDX_W-1:0]                     tgt_i,
   input  logic                                 hs_i,
   input  logic                                 rsp_i,
   output logic                                 issue_ok_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] cnt_o,
   output logic [IDX_W-1:0]                     last_tgt_o
);
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0] last_tgt_q, last_tgt_d;
   logic             rsp;
   always_comb begin
      rsp        = rsp_i && cnt_q != '0;
      issue_ok_o = !rst_i && cnt_q < CW'(MAX_OUTSTANDING) &&
                   (cnt_q == '0 || tgt_i == last_tgt_q || (cnt_q == CW'(1) && rsp));
      cnt_d      = cnt_q + CW'(hs_i) - CW'(rsp);
      last_tgt_d = hs_i ? tgt_i : last_tgt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         last_tgt_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         last_tgt_q <= last_tgt_d;
      end
   end
   assign cnt_o      = cnt_q;
   assign last_tgt_o = last_tgt_q;
endmodule

// File: rtl/tcdm_remap_demux.sv
// tcdm_remap_demux: single-master TCDM demux with alias remap, rule decode and error slave
module tcdm_remap_demux
   import pkg_soc_interconnect::*;
#(
   parameter int unsigned                 NR_TARGETS      = 3,
   parameter int unsigned                 NR_RULES        = 3,
   parameter int unsigned                 ADDR_WIDTH      = 32,
   parameter int unsigned                 DATA_WIDTH      = 32,
   parameter int unsigned                 MAX_OUTSTANDING = 4,
   parameter int unsigned                 PREFIX_WIDTH    = 12,
   parameter bit                          REMAP_EN        = 1'b1,
   parameter logic [PREFIX_WIDTH-1:0]     REMAP_FROM      = 12'h000,
   parameter logic [PREFIX_WIDTH-1:0]     REMAP_TO        = 12'h1c0,
   parameter bit                          DEFAULT_EN      = 1'b1,
   parameter int unsigned                 DEFAULT_IDX     = 0,
   parameter logic [DATA_WIDTH-1:0]       ERR_RDATA       = 32'hBADACCE5
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  addr_map_rule_t [NR_RULES-1:0]        addr_map_i,
   input  logic                                 slv_req_i,
   input  logic [ADDR_WIDTH-1:0]                slv_add_i,
   input  logic                                 slv_wen_i,
   input  logic [DATA_WIDTH-1:0]                slv_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]              slv_be_i,
   output logic                                 slv_gnt_o,
   output logic                                 slv_r_valid_o,
   output logic [DATA_WIDTH-1:0]                slv_r_rdata_o,
   output logic                                 slv_r_opc_o,
   output logic [NR_TARGETS-1:0]                mst_req_o,
   output logic [ADDR_WIDTH-1:0]                mst_add_o     [NR_TARGETS],
   output logic [NR_TARGETS-1:0]                mst_wen_o,
   output logic [DATA_WIDTH-1:0]                mst_wdata_o   [NR_TARGETS],
   output logic [DATA_WIDTH/8-1:0]              mst_be_o      [NR_TARGETS],
   input  logic [NR_TARGETS-1:0]                mst_gnt_i,
   input  logic [NR_TARGETS-1:0]                mst_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                mst_r_rdata_i [NR_TARGETS],
   input  logic [NR_TARGETS-1:0]                mst_r_opc_i,
   output logic                                 err_unmapped_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
   localparam int unsigned IDX_W = tgt_idx_w(NR_TARGETS);
   localparam int unsigned ERR   = err_idx(NR_TARGETS);
   logic [ADDR_WIDTH-1:0] addr;
   logic [IDX_W-1:0]      tgt, last_tgt;
   logic                  issue_ok, gnt_sel, rsp_v, opc_sel, err_valid_q, err_valid_d;
   logic [DATA_WIDTH-1:0] rdata_sel;
   always_comb begin
      addr = slv_add_i;
      if (REMAP_EN && slv_add_i[ADDR_WIDTH-1 -: PREFIX_WIDTH] == REMAP_FROM)
         addr[ADDR_WIDTH-1 -: PREFIX_WIDTH] = REMAP_TO;
      tgt = DEFAULT_EN ? IDX_W'(DEFAULT_IDX) : IDX_W'(ERR);
      // Walk rules from the top so the lowest-index match is applied last; a rule naming a missing port lands on the error slave.
      for (int r = NR_RULES - 1; r >= 0; r--)
         if (32'(addr) >= addr_map_i[r].start_addr && 32'(addr) < addr_map_i[r].end_addr) begin
            tgt = IDX_W'(ERR);
            for (int t = 0; t < NR_TARGETS; t++)
               if (addr_map_i[r].idx == 32'(t)) tgt = IDX_W'(t);
         end
   end
   always_comb begin
      gnt_sel = tgt == IDX_W'(ERR);
      for (int t = 0; t < NR_TARGETS; t++)
         if (tgt == IDX_W'(t)) gnt_sel = mst_gnt_i[t];
      slv_gnt_o      = slv_req_i && issue_ok && gnt_sel;
      err_unmapped_o = slv_gnt_o && tgt == IDX_W'(ERR);
      err_valid_d    = err_unmapped_o;
      for (int t = 0; t < NR_TARGETS; t++) begin
         mst_req_o[t]   = slv_req_i && issue_ok && tgt == IDX_W'(t);
         mst_add_o[t]   = addr;
         mst_wen_o[t]   = slv_wen_i;
         mst_wdata_o[t] = slv_wdata_i;
         mst_be_o[t]    = slv_be_i;
      end
   end
   always_comb begin
      rsp_v     = err_valid_q;
      rdata_sel = ERR_RDATA;
      opc_sel   = 1'b1;
      for (int t = 0; t < NR_TARGETS; t++)
         if (last_tgt == IDX_W'(t)) begin
            rsp_v     = mst_r_valid_i[t];
            rdata_sel = mst_r_rdata_i[t];
            opc_sel   = mst_r_opc_i[t];
         end
      slv_r_valid_o = outstanding_o != '0 && rsp_v;
      slv_r_rdata_o = outstanding_o != '0 ? rdata_sel : '0;
      slv_r_opc_o   = outstanding_o != '0 && opc_sel;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) err_valid_q <= 1'b0;
      else       err_valid_q <= err_valid_d;
   end
   tcdm_outstanding_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .IDX_W           (IDX_W)
   ) i_tracker (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .tgt_i      (tgt),
      .hs_i       (slv_gnt_o),
      .rsp_i      (rsp_v),
      .issue_ok_o (issue_ok),
      .cnt_o      (outstanding_o),
      .last_tgt_o (last_tgt)
   );
endmodule

// File: tb/tb_tcdm_remap_demux.sv
// tb_tcdm_remap_demux: directed bench with latency-programmable slave models and response scoreboard
module tb_tcdm_remap_demux;
   import pkg_soc_interconnect::*;
   logic                       clk = 1'b0, rst_i;
   addr_map_rule_t [2:0]       addr_map;
   logic                       slv_req, slv_wen;
   logic [31:0]                slv_add, slv_wdata;
   logic [3:0]                 slv_be;
   logic                       slv_gnt_o, slv_r_valid_o, slv_r_opc_o, err_unmapped_o;
   logic [31:0]                slv_r_rdata_o;
   logic [2:0]                 mst_req_o, mst_wen_o, mst_r_valid_i, mst_r_opc_i;
   logic [2:0]                 mst_gnt_i = 3'b111;
   logic [31:0]                mst_add_o [3], mst_wdata_o [3], mst_r_rdata_i [3];
   logic [3:0]                 mst_be_o [3];
   logic [2:0]                 outstanding_o;
   typedef struct {int due; logic [31:0] data; logic opc;} exp_t;
   exp_t sb[$];
   exp_t pq[3][$];
   int lat[3];
   int cyc = 0, n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   tcdm_remap_demux #(.DEFAULT_EN(1'b0)) dut (
      .clk_i(clk), .rst_i(rst_i), .addr_map_i(addr_map),
      .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
      .slv_wdata_i(slv_wdata), .slv_be_i(slv_be),
      .slv_gnt_o(slv_gnt_o), .slv_r_valid_o(slv_r_valid_o),
      .slv_r_rdata_o(slv_r_rdata_o), .slv_r_opc_o(slv_r_opc_o),
      .mst_req_o(mst_req_o), .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o),
      .mst_wdata_o(mst_wdata_o), .mst_be_o(mst_be_o),
      .mst_gnt_i(mst_gnt_i), .mst_r_valid_i(mst_r_valid_i),
      .mst_r_rdata_i(mst_r_rdata_i), .mst_r_opc_i(mst_r_opc_i),
      .err_unmapped_o(err_unmapped_o), .outstanding_o(outstanding_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] a);
      @(posedge clk);
      #1;
      rst_i   = r;
      slv_req = q;
      slv_wen = w;
      slv_add = a;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && outstanding_o != 0; i++) drive(0, 0, 1, 0);
      chk("drain", 32'(outstanding_o), 0);
   endtask

   // Reference decode: alias 0x000xxxxx -> 0x1C0xxxxx, then rules in priority order, else error slave (3).
   function automatic void exp_of(input logic [31:0] a, output int port, output logic [31:0] ra);
      ra = (a[31:20] == 12'h000) ? {12'h1c0, a[19:0]} : a;
      if (ra >= 32'h1C00_0000 && ra < 32'h1C08_0000) port = 0;
      else if (ra >= 32'h1000_0000 && ra < 32'h1010_0000) port = 1;
      else if (ra >= 32'h1A00_0000 && ra < 32'h1A10_0000) port = 2;
      else port = 3;
   endfunction

   // Slave models: lat[p] idle cycles between a port handshake and its response.
   initial begin
      mst_r_valid_i = '0;
      mst_r_opc_i   = '0;
      for (int p = 0; p < 3; p++) mst_r_rdata_i[p] = '0;
      forever begin
         @(negedge clk);
         for (int p = 0; p < 3; p++) begin
            exp_t e;
            if (mst_r_valid_i[p]) void'(pq[p].pop_front());
            if (mst_req_o[p] && mst_gnt_i[p]) begin
               e.due  = cyc + lat[p] + 1;
               e.data = mst_add_o[p] ^ 32'h5A5A_0000 ^ 32'(p);
               e.opc  = 1'b0;
               pq[p].push_back(e);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         for (int p = 0; p < 3; p++) begin
            mst_r_valid_i[p] = pq[p].size() != 0 && pq[p][0].due <= cyc;
            mst_r_rdata_i[p] = pq[p].size() != 0 ? pq[p][0].data : 32'h0;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      int port;
      logic [31:0] ra;
      if (slv_r_valid_o) begin
         chk("rsp_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_rdata", slv_r_rdata_o, e.data);
            chk("rsp_opc", 32'(slv_r_opc_o), 32'(e.opc));
            chk("rsp_cycle", cyc, e.due);
         end
      end
      if (slv_req && slv_gnt_o) begin
         exp_of(slv_add, port, ra);
         e.due  = cyc + (port == 3 ? 1 : lat[port] + 1);
         e.data = port == 3 ? 32'hBADACCE5 : ra ^ 32'h5A5A_0000 ^ 32'(port);
         e.opc  = port == 3;
         sb.push_back(e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      automatic logic exp_g[6] = '{1, 1, 1, 1, 0, 1};
      int k, peak, fwd, strays;
      addr_map[0] = '{idx: 32'd0, start_addr: 32'h1C00_0000, end_addr: 32'h1C08_0000};
      addr_map[1] = '{idx: 32'd1, start_addr: 32'h1000_0000, end_addr: 32'h1010_0000};
      addr_map[2] = '{idx: 32'd2, start_addr: 32'h1A00_0000, end_addr: 32'h1A10_0000};
      lat = '{0, 0, 0};
      rst_i = 1'b1; slv_req = 1'b0; slv_wen = 1'b1; slv_add = '0; slv_wdata = '0; slv_be = 4'hF;
      drive(1, 1, 1, 32'h1000_0000);
      chk("rst_gnt", 32'(slv_gnt_o), 0);
      chk("rst_mst_req", 32'(mst_req_o), 0);
      drive(1, 1, 1, 32'h1000_0000);
      chk("rst_cnt", 32'(outstanding_o), 0);
      chk("rst_rvalid", 32'(slv_r_valid_o), 0);
      chk("rst_rdata", slv_r_rdata_o, 0);
      chk("rst_opc", 32'(slv_r_opc_o), 0);
      chk("rst_err", 32'(err_unmapped_o), 0);

      drive(0, 1, 1, 32'h0000_1234);
      chk("remap_req", 32'(mst_req_o), 32'b001);
      chk("remap_add", mst_add_o[0], 32'h1C00_1234);
      chk("remap_gnt", 32'(slv_gnt_o), 1);
      drive(0, 0, 1, 0);
      chk("remap_rvalid", 32'(slv_r_valid_o), 1);
      chk("remap_rdata", slv_r_rdata_o, 32'h1C00_1234 ^ 32'h5A5A_0000);

      drive(0, 1, 0, 32'h5000_0000);
      chk("err_gnt", 32'(slv_gnt_o), 1);
      chk("err_pulse", 32'(err_unmapped_o), 1);
      chk("err_no_mst_req", 32'(mst_req_o), 0);
      drive(0, 0, 1, 0);
      chk("err_rvalid", 32'(slv_r_valid_o), 1);
      chk("err_rdata", slv_r_rdata_o, 32'hBADACCE5);
      chk("err_opc", 32'(slv_r_opc_o), 1);
      chk("err_pulse_end", 32'(err_unmapped_o), 0);
      drive(0, 0, 1, 0);
      chk("err_rvalid_end", 32'(slv_r_valid_o), 0);
      chk("err_cnt", 32'(outstanding_o), 0);

      lat[1] = 3;
      k = 0;
      peak = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 1, 32'h1000_0000 + 32'(4 * k));
         chk($sformatf("limit_gnt%0d", i), 32'(slv_gnt_o), 32'(exp_g[i]));
         if (32'(outstanding_o) > peak) peak = 32'(outstanding_o);
         if (slv_gnt_o) k++;
      end
      chk("limit_peak", peak, 4);
      drive(0, 0, 1, 0);
      drain();

      lat[1] = 1;
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 32'h1000_0100 + 32'(4 * i));
      chk("simul_cnt_before", 32'(outstanding_o), 2);
      drive(0, 0, 1, 0);
      chk("simul_cnt_after", 32'(outstanding_o), 2);
      drain();

      lat[0] = 2;
      lat[1] = 0;
      drive(0, 1, 1, 32'h1C00_0100);
      chk("sw_req0", 32'(mst_req_o), 32'b001);
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 1, 32'h1000_0040);
         chk("sw_held_req", 32'(mst_req_o), 0);
         chk("sw_held_gnt", 32'(slv_gnt_o), 0);
      end
      drive(0, 1, 1, 32'h1000_0040);
      chk("sw_req1", 32'(mst_req_o), 32'b010);
      chk("sw_gnt1", 32'(slv_gnt_o), 1);
      chk("sw_rvalid0", 32'(slv_r_valid_o), 1);
      drive(0, 0, 1, 0);
      chk("sw_rvalid1", 32'(slv_r_valid_o), 1);
      drain();

      lat[1] = 5;
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 32'h1000_0200 + 32'(4 * i));
      drive(1, 1, 1, 32'h1000_0300);
      chk("midrst_gnt", 32'(slv_gnt_o), 0);
      chk("midrst_mst_req", 32'(mst_req_o), 0);
      sb.delete();
      drive(0, 0, 1, 0);
      chk("midrst_cnt", 32'(outstanding_o), 0);
      chk("midrst_rvalid", 32'(slv_r_valid_o), 0);
      chk("midrst_rdata", slv_r_rdata_o, 0);
      chk("midrst_opc", 32'(slv_r_opc_o), 0);
      chk("midrst_err", 32'(err_unmapped_o), 0);
      fwd = 0;
      strays = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 0);
         if (mst_r_valid_i[1]) strays++;
         if (slv_r_valid_o) fwd++;
      end
      chk("midrst_strays_seen", strays, 3);
      chk("midrst_forwarded", fwd, 0);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
